wb_arbiter: RTL and testbench
=============================

# wb_arbiter

Write-back arbiter sharing the single general-register-file write port between the execute unit (ALU/CSR results) and the load/store unit (load data). Accepts one write-back request per cycle over valid/ready handshakes, registers the winner into a one-entry output stage, and drives the register-file write port plus a per-instruction retire pulse. Sits between the EXU/LSU and the register file, replacing direct EXU-to-register-file writes.

## Interface
- DW, 32, data width of register write data
- AW, 5, register address width (2^AW registers, register 0 hard-wired zero)
- clk  in  1  system clock, all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- wb_hold  in  1  freeze: no new grants while high
- exu_valid  in  1  EXU has a result to retire
- exu_ready  out  1  EXU request accepted this cycle
- exu_wen  in  1  EXU result writes a register
- exu_waddr  in  AW  EXU destination register
- exu_wdata  in  DW  EXU result data
- lsu_valid / lsu_ready / lsu_wen / lsu_waddr / lsu_wdata: same as EXU set, for LSU
- rf_wen  out  1  register-file write enable (one-cycle pulse)
- rf_waddr  out  AW  register-file write address
- rf_wdata  out  DW  register-file write data
- wb_finish  out  1  one-cycle pulse per retired instruction
- wb_src  out  1  source of current retire: 0 EXU, 1 LSU
- retired_cnt  out  32  count of retired instructions

## Operation
- Request pending when `x_valid` high; grant at most one request per cycle; no grant while `wb_hold` or `rst` high.
- `x_ready` is combinational: high only in the cycle the requester is granted; transfer = `x_valid & x_ready`.
- Granted request captured into output stage at next edge: `wb_finish`=1, `wb_src`=winner, `rf_waddr`/`rf_wdata` = winner fields, `rf_wen` = winner wen AND waddr≠0.
- Write to register 0: `rf_wen`=0, `wb_finish` still 1, counter still increments.
- No grant: `wb_finish`=0, `rf_wen`=0; `rf_waddr`/`rf_wdata`/`wb_src` hold last values.
- Priority: per Configuration; single requester always wins.
- `retired_cnt` increments by 1 on every cycle `wb_finish` is set; wraps 0xFFFF_FFFF→0.
- Requester must hold valid and fields stable until ready; arbiter never drops an accepted request.

## Timing
- Reset values: `rf_wen`=0, `wb_finish`=0, `wb_src`=0, `rf_waddr`=0, `rf_wdata`=0, `retired_cnt`=0, RR pointer = EXU-first; `exu_ready`=`lsu_ready`=0 during reset.
- Latency: accept in cycle N → `rf_wen`/`wb_finish` high in cycle N+1, exactly one cycle.
- Throughput: one retire per cycle, back-to-back grants allowed.
- Reset asserted in cycle N with a grant-eligible request: no grant, output stage cleared at edge N.
- `wb_hold` asserted: ready low same cycle; an already-captured retire still completes in the following cycle.
- Simultaneous valid: exactly one ready high; loser keeps valid and is served in a later cycle.

## Configuration
- `WB_ARB_RR_EN` defined: round-robin; 1-bit pointer names preferred requester; after each contested grant pointer moves to the loser; uncontested grants leave it unchanged. Under continuous dual requests, grants alternate LSU/EXU starting with EXU after reset.
- Undefined: fixed priority, LSU always beats EXU (loads retire first); pointer logic absent.

## Structure
- Shared package: `WB_SRC_EXU`=1'b0, `WB_SRC_LSU`=1'b1, a write-back request struct (wen, waddr, wdata) typedef.
- One sub-module natural: `wb_rr_pick` (2-way grant logic with pointer, pointer present only under `WB_ARB_RR_EN`).

## Test plan
- Reset: hold `rst` 3 cycles with both valid → both ready 0, all outputs 0, `retired_cnt`=0.
- Single EXU: exu_valid, wen=1, waddr=5, wdata=0x1234 → exu_ready same cycle; next cycle rf_wen=1, rf_waddr=5, rf_wdata=0x1234, wb_src=0, retired_cnt=1.
- x0 write: lsu_valid, wen=1, waddr=0, wdata=0xDEAD → next cycle rf_wen=0, wb_finish=1, wb_src=1, retired_cnt increments.
- Contention 4 cycles, both valid each cycle: with `WB_ARB_RR_EN` grants EXU,LSU,EXU,LSU; without, LSU each cycle, exu_ready stays 0.
- wb_hold high 2 cycles with EXU valid → exu_ready 0, no wb_finish; on release granted, retire one cycle later.
- Counter wrap: force 0xFFFF_FFFF retirements (or preload via bench) then one retire → retired_cnt=0.

Source files
------------

// File: rtl/wb_arbiter_pkg.sv
// wb_arbiter_pkg: shared types and constants for the write-back arbiter.
// WB_ARB_RR_EN selects round-robin arbitration (else fixed LSU priority).
package wb_arbiter_pkg;

  localparam int WB_DW = 32;
  localparam int WB_AW = 5;

  localparam logic WB_SRC_EXU = 1'b0;
  localparam logic WB_SRC_LSU = 1'b1;

  typedef struct packed {
    logic             wen;
    logic [WB_AW-1:0] waddr;
    logic [WB_DW-1:0] wdata;
  } wb_req_t;

endpackage

// File: rtl/wb_rr_pick.sv
// wb_rr_pick: 2-way write-back grant logic.
// WB_ARB_RR_EN: round-robin pointer; otherwise LSU always wins.
module wb_rr_pick
  import wb_arbiter_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic req_exu,
  input  logic req_lsu,
  output logic gnt_exu,
  output logic gnt_lsu
);

`ifdef WB_ARB_RR_EN
  logic ptr_q;
  logic both;

  assign both = req_exu & req_lsu;

  // Grant one requester; on contention the pointer picks.
  always_comb begin
    gnt_exu = 1'b0;
    gnt_lsu = 1'b0;
    if (en) begin
      unique case (1'b1)
        both: begin
          gnt_lsu = (ptr_q == WB_SRC_LSU);
          gnt_exu = (ptr_q == WB_SRC_EXU);
        end
        req_lsu & ~req_exu: gnt_lsu = 1'b1;
        req_exu & ~req_lsu: gnt_exu = 1'b1;
        default: ;
      endcase
    end
  end

  // After a contested grant the loser becomes preferred.
  always_ff @(posedge clk) begin
    if (rst)
      ptr_q <= WB_SRC_EXU;
    else if (en && both)
      ptr_q <= gnt_exu ? WB_SRC_LSU : WB_SRC_EXU;
  end
`else
  logic unused_clk_rst;

  assign unused_clk_rst = clk ^ rst;

  // Fixed priority: loads retire first.
  always_comb begin
    gnt_lsu = en & req_lsu;
    gnt_exu = en & req_exu & ~req_lsu;
  end
`endif

endmodule

// File: rtl/wb_arbiter.sv
// wb_arbiter: shares the register-file write port between EXU and LSU.
// WB_ARB_RR_EN enables round-robin grants in wb_rr_pick.
module wb_arbiter
  import wb_arbiter_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             wb_hold,
  input  logic             exu_valid,
  output logic             exu_ready,
  input  logic             exu_wen,
  input  logic [WB_AW-1:0] exu_waddr,
  input  logic [WB_DW-1:0] exu_wdata,
  input  logic             lsu_valid,
  output logic             lsu_ready,
  input  logic             lsu_wen,
  input  logic [WB_AW-1:0] lsu_waddr,
  input  logic [WB_DW-1:0] lsu_wdata,
  output logic             rf_wen,
  output logic [WB_AW-1:0] rf_waddr,
  output logic [WB_DW-1:0] rf_wdata,
  output logic             wb_finish,
  output logic             wb_src,
  output logic [31:0]      retired_cnt
);

  logic             en;
  logic             gnt_exu;
  logic             gnt_lsu;
  wb_req_t          win;
  logic             wen_q;
  logic             fin_q;
  logic             src_q;
  logic [WB_AW-1:0] waddr_q;
  logic [WB_DW-1:0] wdata_q;
  logic [31:0]      cnt_q;

  assign en = ~wb_hold & ~rst;

  wb_rr_pick u_pick (
    .clk     (clk),
    .rst     (rst),
    .en      (en),
    .req_exu (exu_valid),
    .req_lsu (lsu_valid),
    .gnt_exu (gnt_exu),
    .gnt_lsu (gnt_lsu)
  );

  assign exu_ready = gnt_exu;
  assign lsu_ready = gnt_lsu;

  // Select the winning request fields.
  always_comb begin
    win = '{wen: exu_wen, waddr: exu_waddr, wdata: exu_wdata};
    if (gnt_lsu)
      win = '{wen: lsu_wen, waddr: lsu_waddr, wdata: lsu_wdata};
  end

  // One-entry output stage and retire counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      wen_q   <= 1'b0;
      fin_q   <= 1'b0;
      src_q   <= WB_SRC_EXU;
      waddr_q <= '0;
      wdata_q <= '0;
      cnt_q   <= '0;
    end else begin
      wen_q <= 1'b0;
      fin_q <= 1'b0;
      if (gnt_exu || gnt_lsu) begin
        fin_q   <= 1'b1;
        wen_q   <= win.wen & (|win.waddr);
        src_q   <= gnt_lsu ? WB_SRC_LSU : WB_SRC_EXU;
        waddr_q <= win.waddr;
        wdata_q <= win.wdata;
        cnt_q   <= cnt_q + 32'd1;
      end
    end
  end

  assign rf_wen      = wen_q;
  assign wb_finish   = fin_q;
  assign wb_src      = src_q;
  assign rf_waddr    = waddr_q;
  assign rf_wdata    = wdata_q;
  assign retired_cnt = cnt_q;

endmodule

// File: tb/tb_wb_arbiter.sv
// tb_wb_arbiter: directed and random checks of wb_arbiter
// against a cycle-level reference model of the arbitration rules.
module tb_wb_arbiter;
  import wb_arbiter_pkg::*;

  logic             clk = 1'b0;
  logic             rst;
  logic             wb_hold;
  logic             exu_valid, exu_ready, exu_wen;
  logic [WB_AW-1:0] exu_waddr;
  logic [WB_DW-1:0] exu_wdata;
  logic             lsu_valid, lsu_ready, lsu_wen;
  logic [WB_AW-1:0] lsu_waddr;
  logic [WB_DW-1:0] lsu_wdata;
  logic             rf_wen, wb_finish, wb_src;
  logic [WB_AW-1:0] rf_waddr;
  logic [WB_DW-1:0] rf_wdata;
  logic [31:0]      retired_cnt;

  int n_cmp = 0;
  int n_bad = 0;

  // reference model state
  logic             m_wen, m_fin, m_src;
  logic [WB_AW-1:0] m_addr;
  logic [WB_DW-1:0] m_data;
  logic [31:0]      m_cnt;
  logic             m_pref_lsu;
  string            seq;

  always #5 clk = ~clk;

  wb_arbiter dut (
    .clk         (clk),
    .rst         (rst),
    .wb_hold     (wb_hold),
    .exu_valid   (exu_valid),
    .exu_ready   (exu_ready),
    .exu_wen     (exu_wen),
    .exu_waddr   (exu_waddr),
    .exu_wdata   (exu_wdata),
    .lsu_valid   (lsu_valid),
    .lsu_ready   (lsu_ready),
    .lsu_wen     (lsu_wen),
    .lsu_waddr   (lsu_waddr),
    .lsu_wdata   (lsu_wdata),
    .rf_wen      (rf_wen),
    .rf_waddr    (rf_waddr),
    .rf_wdata    (rf_wdata),
    .wb_finish   (wb_finish),
    .wb_src      (wb_src),
    .retired_cnt (retired_cnt)
  );

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  // One clock: check readies mid-cycle, then outputs after the edge.
  task automatic tick(output logic ge, output logic gl);
    ge = 1'b0;
    gl = 1'b0;
    @(negedge clk);
    if (!rst && !wb_hold) begin
      if (exu_valid && lsu_valid) begin
`ifdef WB_ARB_RR_EN
        gl = m_pref_lsu;
        ge = !m_pref_lsu;
        m_pref_lsu = ge;
`else
        gl = 1'b1;
`endif
      end else begin
        ge = exu_valid;
        gl = lsu_valid;
      end
    end
    check("exu_ready", {31'd0, exu_ready}, {31'd0, ge});
    check("lsu_ready", {31'd0, lsu_ready}, {31'd0, gl});
    if (rst) begin
      m_wen = 0; m_fin = 0; m_src = 0;
      m_addr = 0; m_data = 0; m_cnt = 0;
      m_pref_lsu = 0;
    end else begin
      m_fin = ge | gl;
      m_wen = 1'b0;
      if (ge | gl) begin
        m_src  = gl;
        m_addr = gl ? lsu_waddr : exu_waddr;
        m_data = gl ? lsu_wdata : exu_wdata;
        m_wen  = (gl ? lsu_wen : exu_wen) && (m_addr != 0);
        m_cnt  = m_cnt + 1;
      end
    end
    @(posedge clk);
    #1;
    check("rf_wen", {31'd0, rf_wen}, {31'd0, m_wen});
    check("wb_finish", {31'd0, wb_finish}, {31'd0, m_fin});
    check("wb_src", {31'd0, wb_src}, {31'd0, m_src});
    check("rf_waddr", {27'd0, rf_waddr}, {27'd0, m_addr});
    check("rf_wdata", rf_wdata, m_data);
    check("retired_cnt", retired_cnt, m_cnt);
  endtask

  task automatic new_exu();
    exu_valid = ($urandom_range(2) != 0);
    exu_wen   = $urandom_range(1);
    exu_waddr = WB_AW'($urandom);
    exu_wdata = $urandom;
  endtask

  task automatic new_lsu();
    lsu_valid = ($urandom_range(2) != 0);
    lsu_wen   = $urandom_range(1);
    lsu_waddr = WB_AW'($urandom);
    lsu_wdata = $urandom;
  endtask

  initial begin
    logic ge, gl;
    m_pref_lsu = 0;
    m_wen = 0; m_fin = 0; m_src = 0;
    m_addr = 0; m_data = 0; m_cnt = 0;
    rst = 1; wb_hold = 0;
    exu_valid = 1; exu_wen = 1; exu_waddr = 7; exu_wdata = 32'h11;
    lsu_valid = 1; lsu_wen = 1; lsu_waddr = 9; lsu_wdata = 32'h22;
    #1;

    // reset with both requesting
    repeat (3) tick(ge, gl);
    rst = 0;
    exu_valid = 0; lsu_valid = 0;
    tick(ge, gl);

    // single EXU write
    exu_valid = 1; exu_wen = 1; exu_waddr = 5; exu_wdata = 32'h1234;
    tick(ge, gl);
    check("single_exu_gnt", {31'd0, ge}, 32'd1);
    exu_valid = 0;

    // LSU write to x0
    lsu_valid = 1; lsu_wen = 1; lsu_waddr = 0; lsu_wdata = 32'hDEAD;
    tick(ge, gl);
    check("x0_fin", {31'd0, wb_finish}, 32'd1);
    check("x0_wen", {31'd0, rf_wen}, 32'd0);
    lsu_valid = 0;
    tick(ge, gl);

    // contention for 4 cycles
    seq = "";
    exu_valid = 1; lsu_valid = 1;
    for (int i = 0; i < 4; i++) begin
      exu_waddr = WB_AW'(i + 1); exu_wdata = 32'hE0 + i;
      lsu_waddr = WB_AW'(i + 9); lsu_wdata = 32'hA0 + i;
      tick(ge, gl);
      seq = {seq, wb_src ? "L" : "E"};
    end
`ifdef WB_ARB_RR_EN
    check("contend_seq", {seq.getc(0), seq.getc(1), seq.getc(2), seq.getc(3)},
          {"E", "L", "E", "L"});
`else
    check("contend_seq", {seq.getc(0), seq.getc(1), seq.getc(2), seq.getc(3)},
          {"L", "L", "L", "L"});
`endif
    exu_valid = 0; lsu_valid = 0;
    tick(ge, gl);

    // hold with EXU pending
    exu_valid = 1; exu_waddr = 3; exu_wdata = 32'h55;
    wb_hold = 1;
    repeat (2) tick(ge, gl);
    wb_hold = 0;
    tick(ge, gl);
    check("hold_release_gnt", {31'd0, ge}, 32'd1);
    exu_valid = 0;

    // counter wrap via preload
    dut.cnt_q = 32'hFFFF_FFFF;
    m_cnt = 32'hFFFF_FFFF;
    lsu_valid = 1; lsu_waddr = 4; lsu_wdata = 32'h77;
    tick(ge, gl);
    check("cnt_wrap", retired_cnt, 32'd0);
    lsu_valid = 0;

    // random traffic honouring the hold-until-ready rule
    new_exu();
    new_lsu();
    for (int i = 0; i < 400; i++) begin
      wb_hold = ($urandom_range(9) == 0);
      rst = ($urandom_range(49) == 0);
      tick(ge, gl);
      if (ge || !exu_valid) new_exu();
      if (gl || !lsu_valid) new_lsu();
    end
    rst = 0; wb_hold = 0;
    exu_valid = 0; lsu_valid = 0;
    tick(ge, gl);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
